encode_n_priority_reg: RTL
==========================

# encode_n_priority_reg

Registered, parametrised N-input priority encoder with sticky request capture, selectable fixed or round-robin priority, and a valid/ready output handshake. It generalises the combinational 4:2 priority encoder to N requests. It sits between request sources (interrupt lines, channel requests) and a consumer that takes one encoded index per handshake. Every captured request is reported exactly once per assertion.

## Interface
- N, default 8: number of request inputs, N ≥ 2.
- W, default 3: index width, must equal ceil(log2(N)).
- MODE, default 0: 0 = fixed priority (index 0 highest, as in the 4:2 encoder), 1 = round-robin.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- I  input  N  request pulses or levels; bit k set in a cycle marks request k pending.
- CLR  input  1  synchronous flush.
- RDY  input  1  consumer accepts Y when V=1 and RDY=1.
- Y  output  W  encoded index of the offered request (registered).
- V  output  1  Y is valid (registered).
- PEND  output  N  pending-request register.

## Operation
- Reset (rst_n=0, asynchronous) forces PEND=0, Y=0, V=0, PTR=0 and state IDLE.
- PEND update each edge: PEND ← (PEND & ~ACKMASK) | I.
  - ACKMASK is onehot(Y) when V&RDY, otherwise 0.
  - Set wins: if I[k]=1 in the same cycle bit k is accepted, PEND[k] stays 1 and k is offered again later.
- Selection is a pure function of SRC and PTR:
  - MODE 0: lowest set index of SRC.
  - MODE 1: first set index at or above PTR, ascending, wrapping N-1 → 0.
  - SRC = PEND in IDLE.
  - SRC = PEND & ~onehot(Y) on an accept cycle.
  - SRC never includes the same-cycle I.
- State machine:
  - IDLE (V=0): if PEND≠0, load Y ← selection, V ← 1, go to OFFER. Otherwise stay.
  - OFFER (V=1): Y and V hold while RDY=0. A newly arriving higher-priority request does not preempt.
  - OFFER with RDY=1 (accept): if SRC≠0, load the next selection and stay in OFFER, giving back-to-back throughput of 1 per cycle. Otherwise V ← 0, Y holds its last value, go to IDLE.
- PTR (MODE 1 only): on accept, PTR ← Y+1, wrapping to 0 when Y=N-1. Unchanged otherwise. In MODE 0, PTR is kept at 0.
- CLR=1 has priority over all other activity except reset:
  - PEND ← 0, V ← 0, Y ← 0, PTR ← 0, IDLE.
  - I and RDY are ignored in that cycle.
- RDY while V=0 has no effect.
- N not a power of two: Y never exceeds N-1, and the PTR wrap uses N, not 2^W.

## Timing
- I driven before edge k → PEND bit set at edge k → V=1 with Y after edge k+1. Minimum request-to-valid latency is 2 edges.
- Handshake completes at the edge where V=1 and RDY=1. The next index, if any, is valid after that same edge.
- The accepted bit clears at the accept edge unless I re-sets it.
- V, Y and PEND are register outputs with no combinational path from I or RDY.
- Reset asserted mid-offer clears V immediately (asynchronously). After deassertion the first possible V=1 comes 2 edges after a new request.

## Test plan
- Reset: hold rst_n=0 with I=8'hFF. Expect PEND=0, V=0, Y=0. Release and drop I: expect V to stay 0. Assert rst_n=0 while V=1 mid-stream: expect V=0 before the next edge.
- Fixed priority, MODE 0, N=8: pulse I=8'b1010_0100 for one cycle with RDY=1. Expect Y=2, 5, 7 on three consecutive cycles with V=1, then V=0 and PEND=0.
- Backpressure: MODE 0 offering Y=5 with RDY=0; pulse I[0]. Expect Y to stay 5 and PEND[0]=1. Raise RDY: expect Y=0 next, then the remaining requests.
- Round robin, MODE 1: hold I=8'hFF with RDY=1. Expect Y=0, 1, …, 7, 0, 1 continuously with V=1. With N=6, expect the sequence to wrap 5 → 0.
- Set-wins: MODE 0 offering Y=3; assert I[3] and RDY together. Expect PEND[3]=1 after the edge and index 3 offered again.
- Flush: PEND=8'h0F and V=1; assert CLR with I=8'h80 and RDY=1. Expect PEND=0, V=0, Y=0 and PTR=0 after the edge, with no acceptance recorded.

Source files
------------

// File: rtl/encode_n_priority_reg.sv
// Registered N-input priority encoder with sticky request capture, fixed or round-robin
// selection, and a valid/ready output handshake.
module encode_n_priority_reg #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = 3,
    parameter int unsigned MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] I,
    input  logic         CLR,
    input  logic         RDY,
    output logic [W-1:0] Y,
    output logic         V,
    output logic [N-1:0] PEND
);

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    localparam logic [W-1:0] LastIdx = W'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   onehot_y;
    logic [N-1:0]   src;
    logic [W-1:0]   sel;
    logic           accept;

    function automatic logic [W-1:0] select_idx(input logic [N-1:0] s, input logic [W-1:0] p);
        logic [W-1:0] r;
        logic         found;
        int           k;
        r     = '0;
        found = 1'b0;
        if (MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (s[i]) r = W'(i);
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                k = int'(p) + j;
                if (k >= N) k = k - N;
                if (!found && s[k]) begin
                    r     = W'(k);
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            y_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        onehot_y = {{(N-1){1'b0}}, 1'b1} << y_q;
        accept   = (state_q == StOffer) && RDY;
        src      = accept ? (pend_q & ~onehot_y) : pend_q;

        ptr_d = ptr_q;
        if (MODE != 0 && accept) ptr_d = (y_q == LastIdx) ? '0 : y_q + 1'b1;
        if (MODE == 0) ptr_d = '0;

        // Next pick after an accept searches from the pointer being loaded this edge.
        sel = select_idx(src, ptr_d);

        pend_d  = (pend_q & ~(accept ? onehot_y : '0)) | I;
        state_d = state_q;
        y_d     = y_q;

        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    y_d     = sel;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (accept) begin
                    if (|src) y_d = sel;
                    else      state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (CLR) begin
            pend_d  = '0;
            y_d     = '0;
            ptr_d   = '0;
            state_d = StIdle;
        end
    end

    always_comb begin
        V    = (state_q == StOffer);
        Y    = y_q;
        PEND = pend_q;
    end

endmodule
